// File: rtl/cve2_rvfi_trace_buffer.sv
// ---------------------------------------------------------------------------
// cve2_rvfi_trace_buffer
//
// Purpose:
//   Captures RVFI retirement records from the cve2 core into a circular FIFO
//   and drains them to a trace sink over a valid/ready stream. Only records
//   whose PC falls inside [FilterLo, FilterHi] are captured. A record that
//   arrives while the FIFO is full is lost. Lost records are counted, and
//   once space frees up a gap-marker record is written in their place. The
//   sink uses that marker to detect the discontinuity.
//
// Optional feature (macro CVE2_TRACE_TIMESTAMP_EN):
//   Adds a free-running 64-bit cycle counter. Each record stores the counter
//   value from its capture cycle. A marker stores the value from the cycle in
//   which it is written. The value is presented on trace_time_o.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i              capture enable
//   clear_i               synchronous flush of FIFO, drop counter, sticky flag
//   rvfi_*_i              retirement record from the core
//   trace_valid_o/ready_i head-of-FIFO stream handshake
//   trace_marker_o        head is a gap marker (order = lost count)
//   trace_*_o             head record fields, zero while FIFO is empty
//   level_o               FIFO occupancy
//   overflow_o            sticky, set on the first lost record
//   trace_time_o          capture timestamp (only with CVE2_TRACE_TIMESTAMP_EN)
// ---------------------------------------------------------------------------
module cve2_rvfi_trace_buffer #(
  parameter int unsigned Depth        = 8,
  parameter logic [31:0] FilterLo     = 32'h0000_0000,
  parameter logic [31:0] FilterHi     = 32'hFFFF_FFFF,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    rvfi_valid_i,
  input  logic [63:0]             rvfi_order_i,
  input  logic [31:0]             rvfi_insn_i,
  input  logic                    rvfi_trap_i,
  input  logic [31:0]             rvfi_pc_rdata_i,
  input  logic [4:0]              rvfi_rd_addr_i,
  input  logic [31:0]             rvfi_rd_wdata_i,
  input  logic [31:0]             rvfi_mem_addr_i,
  input  logic [3:0]              rvfi_mem_rmask_i,
  input  logic [3:0]              rvfi_mem_wmask_i,
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output logic                    trace_marker_o,
  output logic [63:0]             trace_order_o,
  output logic [31:0]             trace_pc_o,
  output logic [31:0]             trace_insn_o,
  output logic [31:0]             trace_rd_wdata_o,
  output logic [31:0]             trace_mem_addr_o,
  output logic [4:0]              trace_rd_addr_o,
  output logic [7:0]              trace_mask_o,
  output logic                    trace_trap_o,
`ifdef CVE2_TRACE_TIMESTAMP_EN
  output logic [63:0]             trace_time_o,
`endif
  output logic [$clog2(Depth):0]  level_o,
  output logic                    overflow_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef struct packed {
    logic        marker;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [4:0]  rd_addr;
    logic [7:0]  mask;
    logic        trap;
`ifdef CVE2_TRACE_TIMESTAMP_EN
    logic [63:0] ts;
`endif
  } entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;

  entry_t                  mem_q [Depth];
  entry_t                  wr_entry;
  entry_t                  head;
  entry_t                  head_out;

  logic lo_ok, hi_ok, accept;
  logic empty, full, pop, free_slot;
  logic push, push_marker;

`ifdef CVE2_TRACE_TIMESTAMP_EN
  logic [63:0] cycle_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end
`endif

  // An open window bound would make the compare constant, so it is left out.
  generate
    if (FilterLo == 32'h0000_0000) begin : g_lo_open
      assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign lo_ok = (rvfi_pc_rdata_i >= FilterLo);
    end
    if (FilterHi == 32'hFFFF_FFFF) begin : g_hi_open
      assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign hi_ok = (rvfi_pc_rdata_i <= FilterHi);
    end
  endgenerate

  assign accept = rvfi_valid_i & enable_i & lo_ok & hi_ok;

  // Pointers carry one extra wrap bit: equal means empty, and differing only
  // in the MSB means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop   = ~empty & trace_ready_i;
  // A same-cycle pop frees the slot the push is about to use.
  assign free_slot = ~full | pop;

  // Loss-tracking state machine and push decision.
  always_comb begin
    state_d     = state_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_marker = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          if (free_slot) begin
            push = 1'b1;
          end else begin
            drop_cnt_d = DropCntWidth'(1);
            overflow_d = 1'b1;
            state_d    = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (free_slot) begin
          // The marker always claims the first free slot. A record arriving
          // in the same cycle is lost and starts the next gap count.
          push        = 1'b1;
          push_marker = 1'b1;
          if (accept) begin
            drop_cnt_d = DropCntWidth'(1);
          end else begin
            drop_cnt_d = '0;
            state_d    = S_RUN;
          end
        end else if (accept && (drop_cnt_q != {DropCntWidth{1'b1}})) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (clear_i) begin
      state_d     = S_RUN;
      drop_cnt_d  = '0;
      overflow_d  = 1'b0;
      push        = 1'b0;
      push_marker = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Record to be written: either the incoming retirement or a gap marker.
  always_comb begin
    wr_entry = '0;
    if (push_marker) begin
      wr_entry.marker = 1'b1;
      wr_entry.order  = 64'(drop_cnt_q);
    end else begin
      wr_entry.order    = rvfi_order_i;
      wr_entry.pc       = rvfi_pc_rdata_i;
      wr_entry.insn     = rvfi_insn_i;
      wr_entry.rd_wdata = rvfi_rd_wdata_i;
      wr_entry.mem_addr = rvfi_mem_addr_i;
      wr_entry.rd_addr  = rvfi_rd_addr_i;
      wr_entry.mask     = {rvfi_mem_wmask_i, rvfi_mem_rmask_i};
      wr_entry.trap     = rvfi_trap_i;
    end
`ifdef CVE2_TRACE_TIMESTAMP_EN
    wr_entry.ts = cycle_q;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset. Stale contents are hidden by the empty mask below.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wr_entry;
    end
  end

  assign head     = mem_q[rd_ptr_q[AddrW-1:0]];
  assign head_out = empty ? '0 : head;

  assign trace_valid_o    = ~empty;
  assign trace_marker_o   = head_out.marker;
  assign trace_order_o    = head_out.order;
  assign trace_pc_o       = head_out.pc;
  assign trace_insn_o     = head_out.insn;
  assign trace_rd_wdata_o = head_out.rd_wdata;
  assign trace_mem_addr_o = head_out.mem_addr;
  assign trace_rd_addr_o  = head_out.rd_addr;
  assign trace_mask_o     = head_out.mask;
  assign trace_trap_o     = head_out.trap;
`ifdef CVE2_TRACE_TIMESTAMP_EN
  assign trace_time_o     = head_out.ts;
`endif
  assign level_o          = wr_ptr_q - rd_ptr_q;
  assign overflow_o       = overflow_q;

endmodule

// File: doc/cve2_rvfi_trace_buffer.md
Name: cve2_rvfi_trace_buffer

Overview:
Parametrised RVFI retirement-record buffer for the cve2 core. It captures the per-instruction RVFI fields into a circular FIFO and drains them to a trace sink over a valid/ready stream. It filters records by PC window and tracks lost records. After any loss it inserts a gap-marker record so the sink can detect discontinuities. It sits beside the core in tracing builds and replaces direct, unbuffered tracer hookup.

Parameters:
Depth, 8, FIFO entries; power of two, ≥2
FilterLo, 32'h0000_0000, lowest captured PC, inclusive
FilterHi, 32'hFFFF_FFFF, highest captured PC, inclusive
DropCntWidth, 16, width of the saturating lost-record counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
enable_i  in  1  capture enable; sampled each cycle
clear_i  in  1  synchronous flush of FIFO, drop counter and sticky flag
rvfi_valid_i  in  1  retirement strobe
rvfi_order_i  in  64  retirement order
rvfi_insn_i  in  32  instruction word
rvfi_trap_i  in  1  trap flag
rvfi_pc_rdata_i  in  32  PC of retired instruction
rvfi_rd_addr_i  in  5  destination register
rvfi_rd_wdata_i  in  32  destination write data
rvfi_mem_addr_i  in  32  memory address
rvfi_mem_rmask_i  in  4  read byte mask
rvfi_mem_wmask_i  in  4  write byte mask
trace_valid_o  out  1  head record valid
trace_ready_i  in  1  sink accepts head
trace_marker_o  out  1  head is a gap marker
trace_order_o  out  64  head order; for a marker, {48'0, lost count}
trace_pc_o / trace_insn_o / trace_rd_wdata_o / trace_mem_addr_o  out  32 each  head fields
trace_rd_addr_o  out  5;  trace_mask_o  out  8 ({wmask,rmask});  trace_trap_o  out  1
level_o  out  $clog2(Depth)+1  occupancy
overflow_o  out  1  sticky; set on first loss

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk_i and reset port is rst_i.
- Reset: all outputs are 0, FIFO is empty, drop counter is 0, state is RUN.
- Accept condition: rvfi_valid_i & enable_i & FilterLo ≤ pc ≤ FilterHi. Records that fail the filter are ignored and are not counted as lost.
- Write latency: an accepted record appears at the head one cycle after capture if the FIFO was empty. There is no combinational path from input to output.
- Stream handshake:
  - Pop occurs when trace_valid_o & trace_ready_i.
  - The head and its fields stay stable while valid & !ready.
  - trace_valid_o == (level_o != 0).
- Pointers: rd/wr pointers are $clog2(Depth)+1 bits with natural wrap. Full and empty are derived from the MSB compare.
- Simultaneous push and pop when full: the pop frees a slot in the same cycle, so the push succeeds and nothing is lost. A push and pop when empty lands in the FIFO and is not forwarded.
- State machine:
  - RUN: an accepted record while full (no same-cycle pop) is lost. The drop counter becomes 1, overflow_o is set, and the state goes to DROP.
  - DROP: each further accepted record increments the drop counter, saturating at all-ones. When at least one slot is free at a clock edge with no accepted record, the marker is written (marker=1, order={0,count}, other fields 0). The counter is then cleared and the state goes to RUN.
  - DROP with a free slot and a simultaneous accepted record: the marker takes the slot, the record is counted as lost, and the state stays in DROP.
- clear_i: empties the FIFO, zeroes the counter, clears overflow_o and returns to RUN. It has priority over push and pop in the same cycle.
- enable_i low: capture stops. Drain continues, and a pending marker is still emitted.
- Reset mid-stream discards all contents with no marker.

Optional Feature:
CVE2_TRACE_TIMESTAMP_EN:
- When defined, adds a 64-bit free-running cycle counter (reset 0, wraps) and an output trace_time_o [63:0].
- Each record stores the counter value at its capture cycle. A marker stores the counter value at the cycle it is written.
- When undefined, there is no counter, no port and no storage.

Test Plan:
- Three accepted records with ready=1 and Depth=8 → three pops in order, one cycle after each capture; level_o never exceeds 1.
- ready=0 and 10 accepted records with Depth=8 → 8 stored, overflow_o=1; raise ready → 8 records then a marker with trace_order_o=2.
- Full FIFO with push and pop in the same cycle → level stays 8, no loss, overflow_o stays 0.
- PC 0x0FFF, 0x1000, 0x2000, 0x2001 with FilterLo=0x1000 and FilterHi=0x2000 → only 0x1000 and 0x2000 are output; counter stays 0.
- DropCntWidth=4 with 20 losses → marker count = 15; clear_i asserted with a simultaneous push → level_o=0, overflow_o=0.
- With CVE2_TRACE_TIMESTAMP_EN, captures at cycles 5 and 9 after reset → trace_time_o = 5 then 9.
